hamming_tx_serializer: RTL and testbench

HAMMING_TX_SERIALIZER -- requirements
Module: hamming_tx_serializer

---
 rtl/hamming_pkg.sv | 12 +
 rtl/bit_timer.sv | 27 ++
 rtl/hamming_tx_serializer.sv | 120 ++++++++++++
 tb/tb_hamming_tx_serializer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming transmit path: codeword width and
// serializer FSM states.
package hamming_pkg;
  localparam int HAMMING_CODE_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: bit_tick marks the last cycle of each bit period,
// restart reloads the period so the next bit starts a full period later.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_tick = !restart && (cnt == '0);
endmodule

// File: rtl/hamming_tx_serializer.sv
// Serializes one Hamming codeword per frame: start bit 0, codeword MSB
// first, stop bit 1, each bit held for CLKS_PER_BIT cycles.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000,
  parameter int CODE_W       = HAMMING_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              bit_out,
  output logic              bit_en,
  output logic              frame_done
);
  localparam int IW = $clog2(CODE_W + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CODE_W);

  state_t            state, state_n;
  logic [CODE_W-1:0] shreg, shreg_n;
  logic [IW-1:0]     idx, idx_n;
  logic              bit_out_n, bit_en_n, code_ready_n, frame_done_n;
  logic              restart, bit_tick;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      bit_out    <= 1'b1;
      bit_en     <= 1'b0;
      code_ready <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      idx        <= idx_n;
      bit_out    <= bit_out_n;
      bit_en     <= bit_en_n;
      code_ready <= code_ready_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic computes the registered output values one cycle ahead.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    idx_n        = idx;
    bit_out_n    = 1'b1;
    bit_en_n     = 1'b0;
    code_ready_n = 1'b0;
    frame_done_n = 1'b0;
    restart      = 1'b0;

    case (state)
      IDLE: begin
        restart = 1'b1;
        if (code_ready && code_valid) begin
          state_n   = START;
          shreg_n   = code_in;
          idx_n     = '0;
          bit_out_n = 1'b0;
          bit_en_n  = 1'b1;
        end else begin
          code_ready_n = 1'b1;
        end
      end
      START: begin
        bit_out_n = 1'b0;
        bit_en_n  = 1'b1;
        if (bit_tick) begin
          state_n   = DATA;
          bit_out_n = shreg[CODE_W-1];
          shreg_n   = {shreg[CODE_W-2:0], 1'b0};
          idx_n     = IW'(1);
        end
      end
      DATA: begin
        bit_out_n = bit_out;
        bit_en_n  = 1'b1;
        if (bit_tick) begin
          if (idx == IDX_LAST) begin
            state_n   = STOP;
            bit_out_n = 1'b1;
            idx_n     = '0;
          end else begin
            bit_out_n = shreg[CODE_W-1];
            shreg_n   = {shreg[CODE_W-2:0], 1'b0};
            idx_n     = idx + 1'b1;
          end
        end
      end
      STOP: begin
        bit_out_n = 1'b1;
        bit_en_n  = 1'b1;
        if (bit_tick) begin
          state_n      = IDLE;
          bit_en_n     = 1'b0;
          code_ready_n = 1'b1;
          frame_done_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer with CLKS_PER_BIT=4: directed and random
// frames compared cycle by cycle against a frame-level line model.
module tb_hamming_tx_serializer;
  localparam int CPB     = 4;
  localparam int CW      = 12;
  localparam int NBITS   = CW + 2;
  localparam int FRAME_C = NBITS * CPB;

  logic          clk;
  logic          rst;
  logic [CW-1:0] code_in;
  logic          code_valid;
  logic          code_ready;
  logic          bit_out;
  logic          bit_en;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  hamming_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .CODE_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .bit_out   (bit_out),
    .bit_en    (bit_en),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after acceptance (k = 1 .. FRAME_C).
  function automatic logic exp_bit(input logic [CW-1:0] c, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    else if (b <= CW) return c[CW-b];
    else return 1'b1;
  endfunction

  task automatic send_frame(input logic [CW-1:0] code, input bit hold, input bit corrupt,
                            output int waited);
    waited = 0;
    while (code_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    check("ready_before_accept", code_ready, 1);
    code_in    = code;
    code_valid = 1'b1;
    step();
    if (!hold) code_valid = 1'b0;
    for (int k = 1; k <= FRAME_C; k++) begin
      check("bit_out", bit_out, exp_bit(code, k));
      check("bit_en", bit_en, 1);
      check("ready_busy", code_ready, 0);
      check("done_busy", frame_done, 0);
      if (k == 20) code_in = corrupt ? 12'hAAA : ~code;
      step();
    end
    check("done_pulse", frame_done, 1);
    check("idle_bit_out", bit_out, 1);
    check("idle_bit_en", bit_en, 0);
    check("idle_ready", code_ready, 1);
  endtask

  initial begin
    int w;
    int d0;
    logic [CW-1:0] rc;

    rst        = 1'b1;
    code_valid = 1'b0;
    code_in    = '0;
    repeat (3) step();
    check("rst_bit_out", bit_out, 1);
    check("rst_bit_en", bit_en, 0);
    check("rst_ready", code_ready, 0);
    check("rst_done", frame_done, 0);

    rst = 1'b0;
    step();
    check("ready_after_rst", code_ready, 1);

    for (int i = 0; i < 100; i++) begin
      check("idle_line", bit_out, 1);
      check("idle_en", bit_en, 0);
      check("idle_rdy", code_ready, 1);
      step();
    end

    d0 = done_cnt;
    send_frame(12'h007, 1'b0, 1'b0, w);
    step();
    check("done_count_007", done_cnt - d0, 1);

    d0 = done_cnt;
    send_frame(12'hFFF, 1'b1, 1'b0, w);
    send_frame(12'h000, 1'b0, 1'b0, w);
    check("b2b_no_wait", w, 0);
    step();
    check("done_count_b2b", done_cnt - d0, 2);

    send_frame(12'h555, 1'b0, 1'b1, w);

    for (int i = 0; i < 4; i++) begin
      rc = CW'($urandom);
      repeat ($urandom_range(0, 5)) step();
      send_frame(rc, 1'b0, 1'b0, w);
    end
    step();

    // Abort a frame with reset part way through the data bits.
    rc = CW'($urandom);
    d0 = done_cnt;
    code_in    = rc;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    for (int k = 1; k < 20; k++) begin
      check("pre_abort_bit", bit_out, exp_bit(rc, k));
      step();
    end
    rst = 1'b1;
    step();
    check("abort_bit_out", bit_out, 1);
    check("abort_bit_en", bit_en, 0);
    check("abort_ready", code_ready, 0);
    check("abort_done", frame_done, 0);
    rst = 1'b0;
    step();
    check("abort_ready_back", code_ready, 1);
    for (int i = 0; i < 70; i++) begin
      check("no_resume_en", bit_en, 0);
      check("no_resume_done", frame_done, 0);
      step();
    end
    check("abort_done_count", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
